// File: rtl/weight_biu_pkg.sv
// Shared definitions for the bus-interface units (weight/imap/omap).
// Contents:
//   biu_state_e         BIU fetch FSM states
//   BIU_ADDR_STRIDE     byte increment between consecutive word commands
//   BIU_DEFAULT_MAX_OS  default limit on outstanding read commands
package weight_biu_pkg;

  typedef enum logic [2:0] {
    BIU_IDLE,
    BIU_REQ,
    BIU_ISSUE,
    BIU_DRAIN,
    BIU_DONE
  } biu_state_e;

  localparam int unsigned BIU_ADDR_STRIDE    = 4;
  localparam int unsigned BIU_DEFAULT_MAX_OS = 4;

endpackage

// File: rtl/weight_biu.sv
// Weight bus-interface unit. Fetches LEN consecutive words from system memory
// through the ICB arbiter weight channel and writes them into the weight buffer.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start                      1-cycle launch pulse (accepted only when idle)
//   base_addr, len, wbuf_base  fetch parameters, latched on accepted start
//   busy, done                 busy from accepted start until done; done 1-cycle pulse
//   weight_biu2arb_req/addr/vld, weight_biu2arb_rdy    read-command channel
//   arb2weight_biu_data/vld, arb2weight_biu_rdy        read-response channel
//   wbuf_wr_en/addr/data       registered weight-buffer write port
module weight_biu
  import weight_biu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned MAX_OS  = BIU_DEFAULT_MAX_OS,
  parameter int unsigned WBUF_AW = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [LEN_W-1:0]   len,
  input  logic [WBUF_AW-1:0] wbuf_base,
  output logic               busy,
  output logic               done,
  output logic               weight_biu2arb_req,
  output logic [ADDR_W-1:0]  weight_biu2arb_addr,
  output logic               weight_biu2arb_vld,
  input  logic               weight_biu2arb_rdy,
  input  logic [DATA_W-1:0]  arb2weight_biu_data,
  input  logic               arb2weight_biu_vld,
  output logic               arb2weight_biu_rdy,
  output logic               wbuf_wr_en,
  output logic [WBUF_AW-1:0] wbuf_wr_addr,
  output logic [DATA_W-1:0]  wbuf_wr_data
);

  localparam int unsigned OS_W = $clog2(MAX_OS + 1);

  biu_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [WBUF_AW-1:0] wbase_q, wbase_d;
  logic [LEN_W-1:0]   issued_q, issued_d;
  logic [LEN_W-1:0]   returned_q, returned_d;
  logic [OS_W-1:0]    outst_q, outst_d;
  logic               wr_en_q, wr_en_d;
  logic [WBUF_AW-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;

  logic bus_req;
  logic cmd_vld;
  logic issue_fire;
  logic rsp_fire;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wbase_d    = wbase_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    outst_d    = outst_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    // req spans REQ..DRAIN so the grant is never released mid-fetch; vld and
    // response-ready are both gated by it, which masks a lingering rdy.
    bus_req = (state_q == BIU_REQ) || (state_q == BIU_ISSUE) || (state_q == BIU_DRAIN);
    // The limit uses the registered count, so a same-cycle response cannot
    // unblock an issue at MAX_OS.
    cmd_vld = (state_q == BIU_ISSUE) && (issued_q != len_q) &&
              (outst_q < OS_W'(MAX_OS));
    issue_fire = cmd_vld && weight_biu2arb_rdy;
    rsp_fire   = arb2weight_biu_vld && bus_req;

    if (issue_fire) begin
      addr_d   = addr_q + ADDR_W'(BIU_ADDR_STRIDE);
      issued_d = issued_q + LEN_W'(1);
    end

    if (rsp_fire) begin
      returned_d = returned_q + LEN_W'(1);
      wr_en_d    = 1'b1;
      wr_addr_d  = wbase_q + WBUF_AW'(returned_q);
      wr_data_d  = arb2weight_biu_data;
    end

    unique case ({issue_fire, rsp_fire})
      2'b10:   outst_d = outst_q + OS_W'(1);
      2'b01:   outst_d = outst_q - OS_W'(1);
      default: outst_d = outst_q;
    endcase

    unique case (state_q)
      BIU_IDLE: begin
        if (start) begin
          addr_d     = base_addr;
          len_d      = len;
          wbase_d    = wbuf_base;
          issued_d   = '0;
          returned_d = '0;
          outst_d    = '0;
          state_d    = (len == '0) ? BIU_DONE : BIU_REQ;
        end
      end
      BIU_REQ: begin
        if (weight_biu2arb_rdy) state_d = BIU_ISSUE;
      end
      BIU_ISSUE: begin
        if (issue_fire && (issued_q + LEN_W'(1) == len_q)) state_d = BIU_DRAIN;
      end
      BIU_DRAIN: begin
        if (returned_q == len_q) state_d = BIU_DONE;
      end
      BIU_DONE: begin
        state_d = BIU_IDLE;
      end
      default: state_d = BIU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BIU_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      wbase_q    <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      outst_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wbase_q    <= wbase_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      outst_q    <= outst_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign busy                = bus_req;
  assign done                = (state_q == BIU_DONE);
  assign weight_biu2arb_req  = bus_req;
  assign weight_biu2arb_addr = addr_q;
  assign weight_biu2arb_vld  = cmd_vld;
  assign arb2weight_biu_rdy  = bus_req;
  assign wbuf_wr_en          = wr_en_q;
  assign wbuf_wr_addr        = wr_addr_q;
  assign wbuf_wr_data        = wr_data_q;

endmodule

// File: tb/tb_weight_biu.sv
// Directed bench for weight_biu: arbiter/memory model driven on the falling
// edge, scoreboard of expected buffer writes filled at command acceptance.
module tb_weight_biu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] len = '0;
  logic [9:0]  wbuf_base = '0;
  logic        busy, done;
  logic        req, cvld, crdy;
  logic [31:0] caddr;
  logic [31:0] rdata;
  logic        rvld, rrdy;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;

  weight_biu #(
    .ADDR_W(32), .DATA_W(32), .LEN_W(16), .MAX_OS(4), .WBUF_AW(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .wbuf_base(wbuf_base), .busy(busy), .done(done),
    .weight_biu2arb_req(req), .weight_biu2arb_addr(caddr),
    .weight_biu2arb_vld(cvld), .weight_biu2arb_rdy(crdy),
    .arb2weight_biu_data(rdata), .arb2weight_biu_vld(rvld),
    .arb2weight_biu_rdy(rrdy), .wbuf_wr_en(wr_en), .wbuf_wr_addr(wr_addr),
    .wbuf_wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; int unsigned due; } rsp_t;
  typedef struct { logic [9:0] waddr; logic [31:0] data; } wr_t;

  rsp_t pend[$];
  wr_t  sb[$];

  int unsigned ntests = 0, nfail = 0;
  int unsigned ncnt = 0, lat = 1, gdelay = 2, req_run = 0, linger = 0;
  int unsigned issued_tb = 0, outst_tb = 0, max_os = 0;
  int unsigned done_cnt = 0, req_cycles = 0, wr_cnt = 0;
  logic [31:0] cur_base = '0;
  logic [9:0]  cur_wbase = '0;
  int unsigned cur_len = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  always @(negedge clk) begin
    int unsigned os_before;
    wr_t w;
    ncnt++;
    if (rst) begin
      pend.delete(); sb.delete();
      crdy = 1'b0; rvld = 1'b0; rdata = '0;
      req_run = 0; linger = 0; outst_tb = 0;
    end else begin
      if (wr_en) begin
        wr_cnt++;
        ntests++;
        if (sb.size() == 0) begin
          nfail++; $error("FAIL wr_expected: write with empty scoreboard at addr %0h", wr_addr);
        end else begin
          w = sb.pop_front();
          ntests++;
          if (wr_addr !== w.waddr) begin
            nfail++; $error("FAIL wr_addr observed=%0h expected=%0h", wr_addr, w.waddr);
          end
          ntests++;
          if (wr_data !== w.data) begin
            nfail++; $error("FAIL wr_data observed=%0h expected=%0h", wr_data, w.data);
          end
        end
      end
      if (done) done_cnt++;
      if (req) req_cycles++;

      if (req) begin
        req_run++;
        crdy = (req_run > gdelay);
        linger = crdy ? 1 : 0;
      end else begin
        crdy = (linger != 0);
        linger = 0;
        req_run = 0;
      end
      if ((req && !crdy) || (!req && crdy)) begin
        ntests++;
        if (cvld !== 1'b0) begin
          nfail++; $error("FAIL vld_gated observed=%0h expected=0", cvld);
        end
      end

      os_before = outst_tb;
      if (pend.size() != 0 && pend[0].due <= ncnt) begin
        rvld = 1'b1;
        rdata = pend[0].data;
        if (rrdy) begin
          void'(pend.pop_front());
          outst_tb--;
        end
      end else begin
        rvld = 1'b0;
        rdata = '0;
      end

      if (cvld && crdy) begin
        ntests++;
        if (caddr !== cur_base + 32'(4 * issued_tb)) begin
          nfail++; $error("FAIL cmd_addr observed=%0h expected=%0h", caddr, cur_base + 32'(4 * issued_tb));
        end
        ntests++;
        if (os_before >= 4) begin
          nfail++; $error("FAIL os_limit outstanding=%0d", os_before);
        end
        ntests++;
        if (issued_tb >= cur_len) begin
          nfail++; $error("FAIL cmd_count issued=%0d len=%0d", issued_tb, cur_len);
        end
        pend.push_back('{data: mem_data(caddr), due: ncnt + lat});
        sb.push_back('{waddr: cur_wbase + 10'(issued_tb), data: mem_data(cur_base + 32'(4 * issued_tb))});
        issued_tb++;
        outst_tb++;
        if (outst_tb > max_os) max_os = outst_tb;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    if (obs !== exp) begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] b, input int unsigned l, input logic [9:0] wb);
    @(negedge clk);
    cur_base = b; cur_len = l; cur_wbase = wb;
    issued_tb = 0; done_cnt = 0; req_cycles = 0; wr_cnt = 0; max_os = 0;
    start = 1'b1; base_addr = b; len = 16'(l); wbuf_base = wb;
    @(negedge clk);
    start = 1'b0; base_addr = '0; len = '0; wbuf_base = '0;
  endtask

  task automatic wait_done(input int unsigned bound, input string tag);
    int unsigned n = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    ntests++;
    if (done !== 1'b1) begin
      nfail++; $error("FAIL %s_done_seen: done never observed", tag);
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] b, input int unsigned l,
                       input logic [9:0] wb, input int unsigned lt, input int unsigned gd,
                       input bit poke);
    lat = lt; gdelay = gd;
    do_start(b, l, wb);
    ntests++;
    if (busy !== 1'b1) begin
      nfail++; $error("FAIL %s_busy observed=%0h expected=1", tag, busy);
    end
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1; base_addr = 32'h9000_0000; len = 16'd2; wbuf_base = 10'h200;
      @(negedge clk);
      start = 1'b0; base_addr = '0; len = '0; wbuf_base = '0;
    end
    wait_done(3000, tag);
    @(negedge clk);
    ntests++;
    if (done !== 1'b0) begin
      nfail++; $error("FAIL %s_done_pulse observed=%0h expected=0", tag, done);
    end
    ntests++;
    if (done_cnt != 1) begin
      nfail++; $error("FAIL %s_done_cnt observed=%0d expected=1", tag, done_cnt);
    end
    ntests++;
    if (busy !== 1'b0) begin
      nfail++; $error("FAIL %s_busy_end observed=%0h expected=0", tag, busy);
    end
    ntests++;
    if (issued_tb != l) begin
      nfail++; $error("FAIL %s_issued observed=%0d expected=%0d", tag, issued_tb, l);
    end
    ntests++;
    if (wr_cnt != l) begin
      nfail++; $error("FAIL %s_writes observed=%0d expected=%0d", tag, wr_cnt, l);
    end
    ntests++;
    if (sb.size() != 0) begin
      nfail++; $error("FAIL %s_sb_empty observed=%0d expected=0", tag, sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_req", req, 1'b0);
    chk("rst_vld", cvld, 1'b0);
    chk("rst_addr", caddr, 32'h0);
    chk("rst_rsp_rdy", rrdy, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 10'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    fetch("basic", 32'h0000_1000, 4, 10'h010, 1, 2, 1'b0);

    fetch("bp", 32'h0002_0000, 12, 10'h100, 10, 2, 1'b0);
    chk("bp_max_os", max_os, 4);

    fetch("grant", 32'h0000_4000, 5, 10'h040, 2, 20, 1'b0);
    ntests++;
    if (req_cycles <= 20) begin
      nfail++; $error("FAIL grant_req_cycles observed=%0d expected>20", req_cycles);
    end

    fetch("busy_start", 32'h0000_2000, 6, 10'h020, 3, 2, 1'b1);

    fetch("wrap", 32'hFFFF_FFF8, 4, 10'h3FE, 2, 3, 1'b0);

    do_start(32'h0000_5000, 0, 10'h000);
    chk("len0_done", done, 1'b1);
    chk("len0_req", req, 1'b0);
    chk("len0_busy", busy, 1'b0);
    @(negedge clk);
    chk("len0_done_pulse", done, 1'b0);
    chk("len0_done_cnt", done_cnt, 1);
    chk("len0_req_cycles", req_cycles, 0);

    begin
      int unsigned n = 0;
      lat = 10; gdelay = 2;
      do_start(32'h0000_8000, 8, 10'h080);
      while (issued_tb < 2 && n < 100) begin
        @(negedge clk);
        n++;
      end
      ntests++;
      if (issued_tb < 2) begin
        nfail++; $error("FAIL rstmid_reached_issue issued=%0d", issued_tb);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_req", req, 1'b0);
      chk("rstmid_vld", cvld, 1'b0);
      chk("rstmid_busy", busy, 1'b0);
      chk("rstmid_wr_en", wr_en, 1'b0);
      chk("rstmid_done", done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("rstmid_no_done", done_cnt, 0);
      chk("rstmid_idle_req", req, 1'b0);
    end
    fetch("after_rst", 32'h0000_A000, 3, 10'h0F0, 1, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
